// File: rtl/rv32im_muldiv_unit.sv
// ---------------------------------------------------------------------------
// rv32im_muldiv_unit
// Iterative M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) that
// sits beside the EX-stage ALU. Multiplies use radix-2 shift-add and divides
// use restoring division, one bit per cycle. Divide-by-zero and signed
// overflow are resolved at issue time and skip the iterative phase.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   When defined, the four multiply ops use a single-cycle multiplier and go
//   straight from IDLE to DONE. Divides are unaffected.
//
// Ports
//   CLK      in   clock, rising edge
//   RESET_N  in   synchronous active-low reset
//   start    in   request an operation (sampled in IDLE only)
//   flush    in   abort any operation in flight, priority over start
//   funct3   in   [2:0] operation select
//   op1      in   [XLEN-1:0] rs1 (multiplicand / dividend)
//   op2      in   [XLEN-1:0] rs2 (multiplier / divisor)
//   busy     out  high whenever the FSM is not IDLE
//   valid    out  one-cycle pulse, result valid in that cycle
//   result   out  [XLEN-1:0] registered result, held until next result/reset
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; issue-time decode, operand magnitudes latched
// CALC   | one multiplier/quotient bit per cycle, count 0..XLEN-1
// DONE   | sign fixup and result select; result/valid registered on exit
// ---------------------------------------------------------------------------
module rv32im_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q;
    logic [CNT_W-1:0]    count_q;
    logic [2:0]          fn_q;
    logic [XLEN-1:0]     a_q;        // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   prod_q;     // product, or {0, dividend->quotient}
    logic [XLEN:0]       rem_q;      // partial remainder
    logic                neg_res_q;  // negate product / quotient in DONE
    logic                neg_rem_q;  // negate remainder in DONE
    logic                valid_q;
    logic [XLEN-1:0]     result_q;

    // Issue-time decode of the incoming request
    logic                s1_signed, s2_signed, neg1, neg2;
    logic [XLEN-1:0]     mag1, mag2;
    logic                div_by_zero, div_ovf;

    always_comb begin
        s1_signed   = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
        s2_signed   = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                      (funct3 == 3'b110);
        neg1        = s1_signed && op1[XLEN-1];
        neg2        = s2_signed && op2[XLEN-1];
        mag1        = neg1 ? -op1 : op1;
        mag2        = neg2 ? -op2 : op2;
        div_by_zero = (op2 == '0);
        // Only the signed divide ops (funct3[0] = 0) can overflow
        div_ovf     = !funct3[0] && (op1 == MIN_NEG) && (op2 == ALL_ONES);
    end

    // One iteration of shift-add multiply and restoring divide
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_prod_d;
    logic [XLEN+1:0]     div_part, div_diff;
    logic                div_ok;
    logic [XLEN:0]       div_rem_d;
    logic [2*XLEN-1:0]   div_prod_d;

    always_comb begin
        mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
        mul_prod_d = {mul_sum, prod_q[XLEN-1:1]};

        // Shift the next dividend bit into the remainder and trial-subtract
        div_part   = {rem_q, prod_q[XLEN-1]};
        div_diff   = div_part - {2'b00, a_q};
        div_ok     = ~div_diff[XLEN+1];
        div_rem_d  = div_ok ? div_diff[XLEN:0] : div_part[XLEN:0];
        div_prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], div_ok};
    end

    // Sign fixup and result select, registered on the DONE exit edge
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     rem_fix;
    logic [XLEN-1:0]     res_sel;

    always_comb begin
        prod_fix = neg_res_q ? -prod_q : prod_q;
        rem_fix  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        case (fn_q)
            3'b000:                 res_sel = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_sel = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_sel = prod_fix[XLEN-1:0];
            default:                res_sel = rem_fix;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            fn_q      <= '0;
            a_q       <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (flush) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // The valid cycle is still IDLE; a start held until
                        // valid is seen must not reissue the same op.
                        if (start && !valid_q) begin
                            fn_q    <= funct3;
                            count_q <= '0;
                            rem_q   <= '0;
                            if (funct3[2]) begin
                                if (div_by_zero) begin
                                    // quotient all-ones, remainder = dividend
                                    prod_q    <= {{XLEN{1'b0}}, ALL_ONES};
                                    rem_q     <= {1'b0, op1};
                                    neg_res_q <= 1'b0;
                                    neg_rem_q <= 1'b0;
                                    state_q   <= S_DONE;
                                end else if (div_ovf) begin
                                    prod_q    <= {{XLEN{1'b0}}, op1};
                                    neg_res_q <= 1'b0;
                                    neg_rem_q <= 1'b0;
                                    state_q   <= S_DONE;
                                end else begin
                                    a_q       <= mag2;
                                    prod_q    <= {{XLEN{1'b0}}, mag1};
                                    neg_res_q <= neg1 ^ neg2;
                                    neg_rem_q <= neg1;
                                    state_q   <= S_CALC;
                                end
                            end else begin
                                neg_res_q <= neg1 ^ neg2;
                                neg_rem_q <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
                                prod_q    <= {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
                                state_q   <= S_DONE;
`else
                                a_q       <= mag1;
                                prod_q    <= {{XLEN{1'b0}}, mag2};
                                state_q   <= S_CALC;
`endif
                            end
                        end
                    end
                    S_CALC: begin
                        count_q <= count_q + CNT_W'(1);
                        if (fn_q[2]) begin
                            prod_q <= div_prod_d;
                            rem_q  <= div_rem_d;
                        end else begin
                            prod_q <= mul_prod_d;
                        end
                        if (count_q == CNT_W'(XLEN - 1)) begin
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        result_q <= res_sel;
                        valid_q  <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign valid  = valid_q;
    assign result = result_q;

endmodule

// File: tb/tb_rv32im_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_rv32im_muldiv_unit
// Directed and randomized checks of rv32im_muldiv_unit (XLEN = 32) against a
// plain-arithmetic reference model of the RISC-V M-extension semantics.
// ---------------------------------------------------------------------------
module tb_rv32im_muldiv_unit;

    logic        CLK;
    logic        RESET_N;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] last_res;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    rv32im_muldiv_unit #(.XLEN(32)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .start   (start),
        .flush   (flush),
        .funct3  (funct3),
        .op1     (op1),
        .op2     (op2),
        .busy    (busy),
        .valid   (valid),
        .result  (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // RISC-V M-extension semantics in 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    // start-to-valid cycle count
    function automatic int exp_latency(input logic [2:0] f,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2]) begin
            if (b == 32'd0) return 2;
            if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
            return 34;
        end
        return MUL_LAT;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, hold start until valid, check result/latency/busy time.
    // hold_extra keeps start high through the valid cycle as well.
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit hold_extra);
        logic [31:0] exp_res;
        int          exp_l;
        int          lat;
        int          bcnt;
        bit          got;
        exp_res = ref_op(f, a, b);
        exp_l   = exp_latency(f, a, b);
        @(negedge CLK);
        start  = 1'b1;
        funct3 = f;
        op1    = a;
        op2    = b;
        lat    = 0;
        bcnt   = 0;
        got    = 1'b0;
        while (!got && lat < 100) begin
            @(negedge CLK);
            lat++;
            if (busy) bcnt++;
            if (valid) got = 1'b1;
        end
        check({tag, "_valid_seen"}, 32'(got), 32'd1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_latency"}, 32'(lat), 32'(exp_l));
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_l - 1));
        if (hold_extra) begin
            @(negedge CLK);
            check({tag, "_held_start_ignored"}, 32'(busy), 32'd0);
        end
        start = 1'b0;
        @(negedge CLK);
        check({tag, "_single_valid"}, 32'(valid), 32'd0);
        check({tag, "_result_held"}, result, exp_res);
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
        last_res = exp_res;
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        bit          saw_valid;

        RESET_N = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        funct3  = 3'd0;
        op1     = 32'd0;
        op2     = 32'd0;
        repeat (3) @(negedge CLK);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_result", result, 32'd0);
        last_res = 32'd0;
        RESET_N  = 1'b1;
        @(negedge CLK);

        // Multiply corners
        run_op("mulh_minneg", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("mulh_minneg_const", last_res, 32'h4000_0000);
        run_op("mulhu_ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("mulhu_ones_const", last_res, 32'hFFFF_FFFE);

        // Divide / remainder
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_m7_2_const", last_res, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("rem_m7_2_const", last_res, 32'hFFFF_FFFF);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 1'b0);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 1'b0);

        // Special cases resolved at issue
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 1'b0);
        run_op("remu_by0", 3'd7, 32'd5, 32'd0, 1'b0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_by0", 3'd6, 32'hFFFF_FF00, 32'd0, 1'b0);

        // start held through the valid cycle must not reissue
        run_op("div_hold", 3'd4, 32'd12345, 32'hFFFF_FFFD, 1'b1);

        // Flush at count 10
        @(negedge CLK);
        start  = 1'b1;
        funct3 = 3'd4;
        op1    = 32'd1000;
        op2    = 32'd7;
        @(negedge CLK);
        check("flush_accepted", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check("flush_busy_low", 32'(busy), 32'd0);
        check("flush_no_valid", 32'(valid), 32'd0);
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (valid || busy) saw_valid = 1'b1;
        end
        check("flush_stays_quiet", 32'(saw_valid), 32'd0);
        check("flush_result_unchanged", result, last_res);
        run_op("mul_3x4", 3'd0, 32'd3, 32'd4, 1'b0);
        check("mul_3x4_const", last_res, 32'd12);

        // Reset at count 20
        @(negedge CLK);
        start  = 1'b1;
        funct3 = 3'd5;
        op1    = 32'hDEAD_BEEF;
        op2    = 32'd13;
        @(negedge CLK);
        start = 1'b0;
        repeat (20) @(negedge CLK);
        RESET_N = 1'b0;
        @(negedge CLK);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(valid), 32'd0);
        check("midreset_result", result, 32'd0);
        RESET_N  = 1'b1;
        last_res = 32'd0;
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (valid || busy) saw_valid = 1'b1;
        end
        check("midreset_no_valid", 32'(saw_valid), 32'd0);
        run_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("mulhsu_m1_2_const", last_res, 32'hFFFF_FFFF);

        // Randomized operations, biased toward corner operands
        for (int i = 0; i < 40; i++) begin
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                4: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op("rand", f, a, b, (sel == 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
